// File: rtl/bus_memory_uart.sv
// bus_memory_uart: bus slave for the core. It holds the unified instruction/data RAM and an
// MMIO page. The page contains a FIFO-buffered 8N1 UART transmitter and a free-running
// cycle counter. bus_data_r is decoded combinationally from bus_addr.
module bus_memory_uart #(
    parameter int    RAM_WORDS  = 16384,
    parameter string INIT_FILE  = "",
    parameter int    FIFO_DEPTH = 16,
    parameter int    CLK_DIV    = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    output logic [31:0] bus_data_r,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    input  logic        bus_write,
    output logic        uart_tx
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int          BAUD_W    = $clog2(CLK_DIV);
    localparam logic [31:0] MMIO_BASE = 32'h2000_0000;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;

    // Address decode
    logic ram_sel, uart_data_sel, uart_stat_sel, cycles_sel;
    assign ram_sel       = bus_addr < 32'(RAM_WORDS);
    assign uart_data_sel = bus_addr == MMIO_BASE;
    assign uart_stat_sel = bus_addr == MMIO_BASE + 32'd1;
    assign cycles_sel    = bus_addr == MMIO_BASE + 32'd2;

    logic [RAM_AW-1:0] ram_idx;
    assign ram_idx = bus_addr[RAM_AW-1:0];

    // Unified RAM
    logic [31:0] ram_mem [RAM_WORDS];

    // Byte-lane RAM write.
    // NOTE: the RAM has no reset branch because its contents must survive reset.
    //       A reset branch would also stop the array from mapping onto RAM macros.
    always_ff @(posedge clock) begin
        if (bus_write && ram_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_mask_w[b]) ram_mem[ram_idx][8*b +: 8] <= bus_data_w[8*b +: 8];
            end
        end
    end

    // TX FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic             fifo_empty, fifo_full, push, pop, enq_req;
    logic [31:0]      level_ext;
    logic [3:0]       stat_level;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = level == '0;
    assign fifo_full  = level == (FIFO_AW + 1)'(FIFO_DEPTH);
    assign level_ext  = 32'(level);
    assign stat_level = (level_ext >= 32'd15) ? 4'hF : level_ext[3:0];

    // Store the enqueued byte. When a push coincides with a pop of a full FIFO, the write
    // lands on the head slot. The pop has already captured the old head combinationally.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= bus_data_w[7:0];
    end

    // Transmitter and status state
    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              uart_tx_q, uart_tx_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              baud_tick;

    assign baud_tick = baud_q == BAUD_W'(CLK_DIV - 1);

    // TX FSM next state. A pop happens from IDLE, or on the last STOP clock for back-to-back frames.
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned.
    //       An unassigned output on some path would infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
                    state_d = ST_START;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial line level, registered so that uart_tx is glitch-free.
    always_comb begin
        uart_tx_d = 1'b1;
        case (state_q)
            ST_START: uart_tx_d = 1'b0;
            ST_DATA:  uart_tx_d = shift_q[0];
            default:  uart_tx_d = 1'b1;
        endcase
    end

    // FIFO pointers, sticky overflow flag and cycle counter.
    // A full FIFO still accepts a byte when a pop happens on the same edge.
    always_comb begin
        enq_req  = bus_write && bus_mask_w[0] && uart_data_sel;
        push     = enq_req && (!fifo_full || pop);
        wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (FIFO_AW + 1)'(pop);
        ovf_d    = ovf_q;
        if (bus_write && uart_stat_sel && bus_mask_w[0] && bus_data_w[3]) ovf_d = 1'b0;
        if (enq_req && fifo_full && !pop)                                  ovf_d = 1'b1;
        cycles_d = cycles_q + 32'd1;
    end

    // State registers. Reset aborts any frame in progress and forces the line idle.
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cycles_q  <= cycles_d;
        end
    end

    assign uart_tx = uart_tx_q;

    // Read mux. Unmapped addresses and UART_DATA read as zero.
    always_comb begin
        bus_data_r = 32'd0;
        if (ram_sel)            bus_data_r = ram_mem[ram_idx];
        else if (uart_stat_sel) bus_data_r = {24'd0, stat_level, ovf_q, state_q != ST_IDLE,
                                              fifo_empty, fifo_full};
        else if (cycles_sel)    bus_data_r = cycles_q;
    end

endmodule

// File: tb/tb_bus_memory_uart.sv
// Testbench for bus_memory_uart. A small reference model checks the design: a RAM image,
// a queue of bytes expected on the line, an edge counter, and a serial decoder.
module tb_bus_memory_uart;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 16;
    localparam int          RAM_WORDS  = 64;
    localparam int          FRAME      = 10 * CLK_DIV;
    localparam logic [31:0] UART_DATA  = 32'h2000_0000;
    localparam logic [31:0] UART_STAT  = 32'h2000_0001;
    localparam logic [31:0] CYCLES     = 32'h2000_0002;

    logic        clock, reset, bus_write, uart_tx;
    logic [31:0] bus_addr, bus_data_r, bus_data_w;
    logic [3:0]  bus_mask_w;

    bus_memory_uart #(
        .RAM_WORDS (RAM_WORDS),
        .INIT_FILE (""),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data_r(bus_data_r),
        .bus_data_w(bus_data_w),
        .bus_mask_w(bus_mask_w),
        .bus_write (bus_write),
        .uart_tx   (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Rising edges since reset release. This equals the expected CYCLES value.
    int edge_cnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Reference state
    logic [31:0] ram_model [RAM_WORDS];
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic        mon_active;

    // Serial decoder: finds a falling edge on an idle line and samples each bit mid-period.
    initial begin : monitor
        int         mon_pos;
        int         k;
        logic       mon_prev;
        logic [7:0] mon_byte;
        mon_active = 1'b0;
        mon_prev   = 1'b1;
        mon_pos    = 0;
        mon_byte   = 8'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else if (!mon_active) begin
                if (mon_prev && !uart_tx) begin
                    mon_active = 1'b1;
                    mon_pos    = 0;
                    mon_byte   = 8'd0;
                    start_q.push_back(edge_cnt);
                end
                mon_prev = uart_tx;
            end else begin
                mon_pos++;
                if ((mon_pos % CLK_DIV) == CLK_DIV / 2) begin
                    k = mon_pos / CLK_DIV;
                    if (k == 0) begin
                        check("rx_start_bit", 32'(uart_tx), 32'd0);
                    end else if (k <= 8) begin
                        mon_byte[k-1] = uart_tx;
                    end else begin
                        check("rx_stop_bit", 32'(uart_tx), 32'd1);
                        if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                        else                   check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                        mon_active = 1'b0;
                        mon_prev   = uart_tx;
                    end
                end
            end
        end
    end

    // Drives one write. It is sampled at the next rising edge, and that edge number is returned.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                            output int edge_o);
        bus_addr   = addr;
        bus_data_w = data;
        bus_mask_w = mask;
        bus_write  = 1'b1;
        @(negedge clock);
        bus_write  = 1'b0;
        edge_o     = edge_cnt;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        bus_addr = addr;
        #1;
        check(tag, bus_data_r, expected);
    endtask

    task automatic wait_until(input int n);
        while (edge_cnt < n) @(negedge clock);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 32'(n < limit), 32'd1);
        repeat (2 * CLK_DIV) @(negedge clock);
    endtask

    initial begin : stimulus
        int          e, w, lows;
        logic [31:0] d;
        logic [3:0]  m;
        logic [7:0]  b, x;
        int          a;

        reset      = 1'b0;
        bus_addr   = 32'd0;
        bus_data_w = 32'd0;
        bus_mask_w = 4'd0;
        bus_write  = 1'b0;

        // Reset state and cycle counter
        repeat (3) @(negedge clock);
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        reset = 1'b1;
        read_check("stat_after_reset", UART_STAT, 32'h0000_0002);
        check("idle_uart_tx", 32'(uart_tx), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            read_check("cycles_count", CYCLES, 32'(edge_cnt));
        end

        // RAM: full random fill, random partial writes, readback
        for (int i = 0; i < RAM_WORDS; i++) begin
            d = $urandom;
            do_write(32'(i), d, 4'hF, e);
            ram_model[i] = d;
        end
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, RAM_WORDS - 1);
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            do_write(32'(a), d, m, e);
            for (int j = 0; j < 4; j++) if (m[j]) ram_model[a][8*j +: 8] = d[8*j +: 8];
        end
        for (int i = 0; i < RAM_WORDS; i++) begin
            @(negedge clock);
            read_check("ram_random", 32'(i), ram_model[i]);
        end

        // Byte-lane merge on word 5
        do_write(32'd5, 32'h1234_5678, 4'b1111, e);
        do_write(32'd5, 32'h0000_AB00, 4'b0010, e);
        ram_model[5] = 32'h1234_AB78;
        read_check("ram_lane_merge", 32'd5, 32'h1234_AB78);

        // Unmapped addresses: writes have no effect and reads return zero
        do_write(32'(RAM_WORDS), 32'hDEAD_BEEF, 4'hF, e);
        read_check("ram_no_alias", 32'd0, ram_model[0]);
        read_check("unmapped_above_ram", 32'(RAM_WORDS), 32'd0);
        read_check("unmapped_mmio_3", 32'h2000_0003, 32'd0);
        read_check("uart_data_reads_0", UART_DATA, 32'd0);
        read_check("unmapped_byte_base", 32'h8000_0000, 32'd0);
        do_write(CYCLES, 32'h0, 4'hF, e);
        read_check("cycles_write_ignored", CYCLES, 32'(edge_cnt));

        // Single frame 0xA5: check latency and the exact waveform
        start_q.delete();
        b = 8'hA5;
        exp_q.push_back(b);
        do_write(UART_DATA, 32'(b), 4'b0001, w);
        check("tx_high_before_start", 32'(uart_tx), 32'd1);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                wait_until(w + 2 + CLK_DIV * j + c);
                check("tx_wave_a5", 32'(uart_tx), (j == 0) ? 32'd0 : (j == 9) ? 32'd1 : 32'(b[j-1]));
            end
        end
        wait_drain(4 * FRAME);
        check("start_latency", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(w + 2));

        // Random bytes sent at random gaps
        for (int i = 0; i < 8; i++) begin
            x = 8'($urandom);
            exp_q.push_back(x);
            do_write(UART_DATA, {24'($urandom), x}, 4'b0001, e);
            repeat ($urandom_range(0, 60)) @(negedge clock);
        end
        wait_drain(10 * FRAME);
        read_check("stat_idle_after_random", UART_STAT, 32'h0000_0002);

        // Overflow: one byte in flight, 16 fill the FIFO, a 17th is dropped
        b = 8'($urandom);
        exp_q.push_back(b);
        do_write(UART_DATA, 32'(b), 4'b0001, w);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            x = 8'($urandom);
            exp_q.push_back(x);
            do_write(UART_DATA, 32'(x), 4'b0001, e);
        end
        do_write(UART_DATA, 32'h0000_00EE, 4'b0001, e);
        read_check("stat_full_ovf", UART_STAT, 32'h0000_00FD);
        do_write(UART_STAT, 32'h0000_0008, 4'b0001, e);
        read_check("stat_ovf_cleared", UART_STAT, 32'h0000_00F5);
        // A write on the same edge as the STOP-end pop is accepted even though the FIFO is full.
        wait_until(w + FRAME);
        x = 8'($urandom);
        exp_q.push_back(x);
        do_write(UART_DATA, 32'(x), 4'b0001, e);
        read_check("stat_full_push_pop", UART_STAT, 32'h0000_00F5);
        wait_drain(20 * FRAME);
        read_check("stat_after_overflow_drain", UART_STAT, 32'h0000_0002);

        // Back-to-back frames
        start_q.delete();
        for (int i = 0; i < 2; i++) begin
            x = 8'($urandom);
            exp_q.push_back(x);
            do_write(UART_DATA, 32'(x), 4'b0001, e);
        end
        wait_drain(4 * FRAME);
        check("b2b_frame_count", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) check("b2b_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // Reset during data bit 3 aborts the frame immediately
        b = 8'($urandom) & 8'hF7;
        do_write(UART_DATA, 32'(b), 4'b0001, w);
        wait_until(w + 2 + CLK_DIV * 4 + 1);
        check("tx_bit3_before_reset", 32'(uart_tx), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_tx", 32'(uart_tx), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        read_check("stat_after_midframe_reset", UART_STAT, 32'h0000_0002);
        read_check("ram_kept_over_reset", 32'd5, ram_model[5]);
        read_check("cycles_after_reset", CYCLES, 32'(edge_cnt));
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_resumed_frame", 32'(lows), 32'd0);
        check("all_bytes_received", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
